cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
- Shares one iterative CORDIC core among N requesters.
- Round-robin arbitration selects a requester, latches its 8-bit angle and pulses the core start.
- Waits for core completion, or times out, then returns the 8-bit result tagged with the requester ID over a valid/ready response port.
- Sits between the angle-producing blocks and the CORDIC core. Angle format is the core's: unsigned 8-bit, full scale 256 = 90 deg (e.g. 210 = 73.8 deg).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; equals clog2(N_REQ).
- TIMEOUT_CYCLES, 32, maximum WAIT cycles before the job is abandoned (≥ 2).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_PULSE  in  1  asynchronous, active-low reset.
- REQ_VALID  in  N_REQ  per-requester request valid.
- REQ_ANGLE  in  8*N_REQ  per-requester angle; requester i occupies bits [8i+7:8i].
- REQ_READY  out  N_REQ  one-hot grant/accept.
- CORE_START  out  1  single-cycle start pulse to the core.
- CORE_ANGLE  out  8  angle to the core, held stable from ISSUE until return to IDLE.
- CORE_DONE  in  1  core completion pulse.
- CORE_RESULT  in  8  core output, valid when CORE_DONE=1.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  ID_W  requester index of this response.
- RSP_VALUE  out  8  result (0 on timeout).
- RSP_ERR  out  1  1 = job timed out.
- BUSY  out  1  1 whenever state ≠ IDLE.

Behaviour:
- Reset (RESET_PULSE=0, asynchronous):
  - state=IDLE; rr_ptr=N_REQ-1, so requester 0 has first priority.
  - All outputs 0; CORE_ANGLE=0, RSP_ID=0, RSP_VALUE=0.
  - Reset mid-job abandons the job; no response is emitted for it.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any REQ_VALID, grant g = first asserted index scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - REQ_READY[g]=1 combinationally this cycle; that cycle is the transfer.
  - Latch REQ_ANGLE[g] into CORE_ANGLE and g into RSP_ID; set rr_ptr←g; go to ISSUE.
  - REQ_READY is 0 in every other state.
- Requester rule: REQ_VALID must be held with a stable angle until REQ_READY. The arbiter never withdraws a grant.
- ISSUE: CORE_START=1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT:
  - CORE_DONE is sampled only in this state; a CORE_DONE seen in IDLE/ISSUE/RESPOND is ignored.
  - Counter increments each WAIT cycle.
  - On CORE_DONE=1: RSP_VALUE←CORE_RESULT, RSP_ERR←0, go to RESPOND.
  - Else if counter == TIMEOUT_CYCLES-1: RSP_VALUE←0, RSP_ERR←1, go to RESPOND.
  - If CORE_DONE arrives on the timeout cycle, CORE_DONE wins (RSP_ERR=0).
- RESPOND:
  - RSP_VALID=1; RSP_ID/RSP_VALUE/RSP_ERR held stable until RSP_READY=1.
  - On RSP_VALID&RSP_READY, go to IDLE next cycle. RSP_VALID drops that cycle.
- Latency: accept at cycle t; CORE_START at t+1; if the core raises DONE k cycles after start (k ≥ 1), RSP_VALID rises at t+1+k+1.
- Throughput: at most one job in flight. A new grant is possible in the first IDLE cycle after the response handshake.
- Fairness: a continuously requesting requester waits at most N_REQ-1 jobs.
- Wrap-around: rr_ptr wraps N_REQ-1 → 0. A lone requester is re-granted back-to-back.
- Registered outputs: RSP_*, CORE_ANGLE. REQ_READY, CORE_START and BUSY are decoded from state/grant.

Test Plan:
- Single job: requester 2 sends 210; core model returns 211 with DONE 8 cycles after start. Expect CORE_START one cycle after accept, CORE_ANGLE=210, RSP_VALID 10 cycles after accept, RSP_ID=2, RSP_VALUE=211, RSP_ERR=0.
- Contention: all 4 REQ_VALID held high from reset release (each sending angle 10·i). Expect grant order 0,1,2,3,0; exactly one REQ_READY bit per accept; RSP_ID sequence matches.
- Timeout: core model never raises DONE, TIMEOUT_CYCLES=32. Expect RSP_VALID 33 cycles after CORE_START with RSP_VALUE=0, RSP_ERR=1. Next job then completes normally.
- Backpressure: RSP_READY held low 5 cycles after RSP_VALID. Expect RSP_* stable, no new REQ_READY until the handshake, then grant in the next IDLE cycle.
- Reset mid-WAIT: drop RESET_PULSE 3 cycles after CORE_START. Expect all outputs 0 immediately, BUSY=0, no response for the job, requester 0 granted first after release.
- DONE coincident with timeout cycle, and a spurious DONE in IDLE: expect RSP_ERR=0 with the core result; the IDLE DONE causes no state change.

Source files
------------

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Shares one iterative CORDIC core among N_REQ requesters. A round-robin
//   arbiter accepts one angle at a time, pulses the core start, waits for the
//   core to finish (or abandons the job after TIMEOUT_CYCLES), then returns
//   the result tagged with the requester index over a valid/ready port.
//
// Ports
//   CLK, RESET_PULSE          clock (rising edge), asynchronous active-low reset
//   REQ_VALID/REQ_ANGLE       per-requester request; angle i at [8i+7:8i]
//   REQ_READY                 one-hot grant, asserted combinationally in IDLE
//   CORE_START/CORE_ANGLE     start pulse and held angle to the core
//   CORE_DONE/CORE_RESULT     core completion pulse and result
//   RSP_VALID/RSP_READY       response handshake
//   RSP_ID/RSP_VALUE/RSP_ERR  requester index, result (0 on timeout), timeout flag
//   BUSY                      high whenever a job is in flight
module cordic_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_PULSE,
  input  logic [N_REQ-1:0]     REQ_VALID,
  input  logic [8*N_REQ-1:0]   REQ_ANGLE,
  output logic [N_REQ-1:0]     REQ_READY,
  output logic                 CORE_START,
  output logic [7:0]           CORE_ANGLE,
  input  logic                 CORE_DONE,
  input  logic [7:0]           CORE_RESULT,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [ID_W-1:0]      RSP_ID,
  output logic [7:0]           RSP_VALUE,
  output logic                 RSP_ERR,
  output logic                 BUSY
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] wait_cnt;

  logic [7:0]       angle_arr [N_REQ];
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_angle
    assign angle_arr[g] = REQ_ANGLE[8*g+7:8*g];
  end

  // Round-robin search: first asserted requester after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!grant_any && REQ_VALID[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Gated by reset so a requester holding VALID during reset never sees a
  // grant that the held-in-reset FSM would not honour.
  always_comb begin
    REQ_READY = '0;
    if (state == ST_IDLE && RESET_PULSE && grant_any) begin
      REQ_READY[grant_idx] = 1'b1;
    end
  end

  assign CORE_START = (state == ST_ISSUE);
  assign BUSY       = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge RESET_PULSE) begin
    if (!RESET_PULSE) begin
      state      <= ST_IDLE;
      rr_ptr     <= ID_W'(N_REQ - 1);
      wait_cnt   <= '0;
      CORE_ANGLE <= '0;
      RSP_VALID  <= 1'b0;
      RSP_ID     <= '0;
      RSP_VALUE  <= '0;
      RSP_ERR    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            CORE_ANGLE <= angle_arr[grant_idx];
            RSP_ID     <= grant_idx;
            rr_ptr     <= grant_idx;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // DONE takes priority over a coincident timeout.
          if (CORE_DONE) begin
            RSP_VALUE <= CORE_RESULT;
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
            state     <= ST_RESPOND;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            RSP_VALUE <= '0;
            RSP_ERR   <= 1'b1;
            RSP_VALID <= 1'b1;
            state     <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter
//   Directed bench for cordic_arbiter. A small core model answers each
//   CORE_START after core_delay cycles with CORE_ANGLE+1 (or never, when
//   core_enable is 0). Each scenario task drives stimulus and checks inline.
module tb_cordic_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_PULSE;
  logic [3:0]  REQ_VALID;
  logic [31:0] REQ_ANGLE;
  logic [3:0]  REQ_READY;
  logic        CORE_START;
  logic [7:0]  CORE_ANGLE;
  logic        CORE_DONE;
  logic [7:0]  CORE_RESULT;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [1:0]  RSP_ID;
  logic [7:0]  RSP_VALUE;
  logic        RSP_ERR;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  // core model controls
  logic        core_enable = 1'b1;
  int          core_delay  = 3;
  logic        force_done  = 1'b0;
  logic        model_done;
  int          mcnt;

  assign CORE_DONE = model_done | force_done;

  cordic_arbiter #(
    .N_REQ(4),
    .ID_W(2),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .CLK(CLK),
    .RESET_PULSE(RESET_PULSE),
    .REQ_VALID(REQ_VALID),
    .REQ_ANGLE(REQ_ANGLE),
    .REQ_READY(REQ_READY),
    .CORE_START(CORE_START),
    .CORE_ANGLE(CORE_ANGLE),
    .CORE_DONE(CORE_DONE),
    .CORE_RESULT(CORE_RESULT),
    .RSP_VALID(RSP_VALID),
    .RSP_READY(RSP_READY),
    .RSP_ID(RSP_ID),
    .RSP_VALUE(RSP_VALUE),
    .RSP_ERR(RSP_ERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // DONE rises k cycles after the start cycle: the negedge inside the start
  // cycle loads k, and the negedge k cycles later raises DONE for one cycle.
  always @(negedge CLK) begin
    if (!RESET_PULSE) begin
      mcnt       <= 0;
      model_done <= 1'b0;
    end else if (CORE_START && core_enable) begin
      mcnt       <= core_delay;
      model_done <= 1'b0;
    end else if (mcnt == 1) begin
      mcnt        <= 0;
      model_done  <= 1'b1;
      CORE_RESULT <= CORE_ANGLE + 8'd1;
    end else begin
      model_done <= 1'b0;
      if (mcnt != 0) mcnt <= mcnt - 1;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_PULSE = 1'b0;
    REQ_VALID   = '0;
    RSP_READY   = 1'b1;
    force_done  = 1'b0;
    core_enable = 1'b1;
    core_delay  = 3;
    tick();
    tick();
    RESET_PULSE = 1'b1;
  endtask

  task automatic test_reset();
    RESET_PULSE = 1'b0;
    RSP_READY   = 1'b1;
    REQ_ANGLE   = {8'd4, 8'd3, 8'd2, 8'd1};
    REQ_VALID   = 4'hF;
    tick();
    tick();
    checks++;
    if (REQ_READY !== 4'b0000 || CORE_START !== 1'b0 || BUSY !== 1'b0 || RSP_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b start=%b busy=%b rsp_valid=%b expected all 0",
               REQ_READY, CORE_START, BUSY, RSP_VALID);
    end
    checks++;
    if (CORE_ANGLE !== 8'd0 || RSP_ID !== 2'd0 || RSP_VALUE !== 8'd0 || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got angle=%0d id=%0d value=%0d err=%b expected 0 0 0 0",
               CORE_ANGLE, RSP_ID, RSP_VALUE, RSP_ERR);
    end
    RESET_PULSE = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_priority: got %b expected 0001", REQ_READY);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    core_delay = 8;
    REQ_ANGLE  = {8'd0, 8'd210, 8'd0, 8'd0};
    REQ_VALID  = 4'b0100;
    #1;
    checks++;
    if (REQ_READY !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0100", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    n = 1;
    checks++;
    if (CORE_START !== 1'b1 || CORE_ANGLE !== 8'd210 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: got start=%b angle=%0d busy=%b expected 1 210 1",
               CORE_START, CORE_ANGLE, BUSY);
    end
    tick();
    n = 2;
    checks++;
    if (CORE_START !== 1'b0) begin
      errors++;
      $display("FAIL single_start_pulse: got %b expected 0", CORE_START);
    end
    while (!RSP_VALID && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL single_latency: got %0d expected 10", n);
    end
    checks++;
    if (RSP_ID !== 2'd2 || RSP_VALUE !== 8'd211 || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: got id=%0d value=%0d err=%b expected 2 211 0",
               RSP_ID, RSP_VALUE, RSP_ERR);
    end
    tick();
    checks++;
    if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got rsp_valid=%b busy=%b expected 0 0", RSP_VALID, BUSY);
    end
  endtask

  task automatic test_contention();
    int n;
    int w;
    int bad;
    int exp_id;
    logic [3:0] expv;
    RESET_PULSE = 1'b0;
    RSP_READY   = 1'b1;
    core_enable = 1'b1;
    core_delay  = 3;
    REQ_ANGLE   = {8'd30, 8'd20, 8'd10, 8'd0};
    REQ_VALID   = 4'hF;
    tick();
    tick();
    RESET_PULSE = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp_id = j % 4;
      expv   = 4'b0001 << exp_id;
      #1;
      w = 0;
      while (REQ_READY == 4'b0000 && w < 20) begin
        tick();
        w++;
      end
      checks++;
      if (REQ_READY !== expv || w != 0) begin
        errors++;
        $display("FAIL contention_grant%0d: got %b after %0d idle cycles expected %b after 0",
                 j, REQ_READY, w, expv);
      end
      tick();
      n   = 1;
      bad = 0;
      while (!RSP_VALID && n < 40) begin
        if (REQ_READY !== 4'b0000) bad++;
        tick();
        n++;
      end
      if (REQ_READY !== 4'b0000) bad++;
      checks++;
      if (bad != 0 || n != 5) begin
        errors++;
        $display("FAIL contention_job%0d: got stray_ready=%0d latency=%0d expected 0 and 5",
                 j, bad, n);
      end
      checks++;
      if (RSP_ID !== exp_id[1:0] || RSP_VALUE !== 8'(10 * exp_id + 1) || RSP_ERR !== 1'b0) begin
        errors++;
        $display("FAIL contention_rsp%0d: got id=%0d value=%0d err=%b expected %0d %0d 0",
                 j, RSP_ID, RSP_VALUE, RSP_ERR, exp_id, 10 * exp_id + 1);
      end
      tick();
    end
    REQ_VALID = '0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    core_enable = 1'b0;
    REQ_ANGLE   = {8'd0, 8'd0, 8'd50, 8'd0};
    REQ_VALID   = 4'b0010;
    #1;
    checks++;
    if (REQ_READY !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_grant: got %b expected 0010", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    checks++;
    if (CORE_START !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: got %b expected 1", CORE_START);
    end
    n = 0;
    while (!RSP_VALID && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected 33", n);
    end
    checks++;
    if (RSP_ID !== 2'd1 || RSP_VALUE !== 8'd0 || RSP_ERR !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rsp: got id=%0d value=%0d err=%b expected 1 0 1",
               RSP_ID, RSP_VALUE, RSP_ERR);
    end
    tick();
    core_enable = 1'b1;
    core_delay  = 4;
    REQ_ANGLE   = {8'd0, 8'd0, 8'd77, 8'd0};
    REQ_VALID   = 4'b0010;
    #1;
    checks++;
    if (REQ_READY !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_regrant: got %b expected 0010", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    n = 1;
    while (!RSP_VALID && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 6 || RSP_ID !== 2'd1 || RSP_VALUE !== 8'd78 || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got latency=%0d id=%0d value=%0d err=%b expected 6 1 78 0",
               n, RSP_ID, RSP_VALUE, RSP_ERR);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    do_reset();
    core_delay = 2;
    RSP_READY  = 1'b0;
    REQ_ANGLE  = {8'd99, 8'd0, 8'd0, 8'd5};
    REQ_VALID  = 4'b0001;
    #1;
    checks++;
    if (REQ_READY !== 4'b0001) begin
      errors++;
      $display("FAIL bp_grant: got %b expected 0001", REQ_READY);
    end
    tick();
    REQ_VALID = 4'b1000;
    n   = 1;
    bad = 0;
    while (!RSP_VALID && n < 40) begin
      if (REQ_READY !== 4'b0000) bad++;
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d expected 4", n);
    end
    for (int i = 0; i < 5; i++) begin
      if (RSP_VALID !== 1'b1 || RSP_ID !== 2'd0 || RSP_VALUE !== 8'd6 || RSP_ERR !== 1'b0 ||
          REQ_READY !== 4'b0000 || BUSY !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable or granting cycles expected 0", bad);
    end
    RSP_READY = 1'b1;
    #1;
    checks++;
    if (RSP_VALID !== 1'b1 || REQ_READY !== 4'b0000 || RSP_VALUE !== 8'd6) begin
      errors++;
      $display("FAIL bp_handshake: got rsp_valid=%b ready=%b value=%0d expected 1 0000 6",
               RSP_VALID, REQ_READY, RSP_VALUE);
    end
    tick();
    checks++;
    if (RSP_VALID !== 1'b0 || REQ_READY !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next_grant: got rsp_valid=%b ready=%b expected 0 1000",
               RSP_VALID, REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    n = 1;
    while (!RSP_VALID && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 4 || RSP_ID !== 2'd3 || RSP_VALUE !== 8'd100) begin
      errors++;
      $display("FAIL bp_second_job: got latency=%0d id=%0d value=%0d expected 4 3 100",
               n, RSP_ID, RSP_VALUE);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    do_reset();
    core_delay = 20;
    REQ_ANGLE  = {8'd0, 8'd40, 8'd0, 8'd7};
    REQ_VALID  = 4'b0100;
    #1;
    tick();
    REQ_VALID = '0;
    checks++;
    if (CORE_START !== 1'b1 || CORE_ANGLE !== 8'd40) begin
      errors++;
      $display("FAIL rst_mid_issue: got start=%b angle=%0d expected 1 40", CORE_START, CORE_ANGLE);
    end
    tick();
    tick();
    tick();
    RESET_PULSE = 1'b0;
    REQ_VALID   = 4'b0101;
    #1;
    checks++;
    if (BUSY !== 1'b0 || CORE_START !== 1'b0 || RSP_VALID !== 1'b0 || REQ_READY !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got busy=%b start=%b rsp_valid=%b ready=%b expected 0 0 0 0000",
               BUSY, CORE_START, RSP_VALID, REQ_READY);
    end
    checks++;
    if (CORE_ANGLE !== 8'd0 || RSP_ID !== 2'd0 || RSP_VALUE !== 8'd0 || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_data: got angle=%0d id=%0d value=%0d err=%b expected 0 0 0 0",
               CORE_ANGLE, RSP_ID, RSP_VALUE, RSP_ERR);
    end
    tick();
    tick();
    RESET_PULSE = 1'b1;
    #1;
    checks++;
    if (REQ_READY !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_first_grant: got %b expected 0001", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    n = 1;
    while (!RSP_VALID && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 22 || RSP_ID !== 2'd0 || RSP_VALUE !== 8'd8) begin
      errors++;
      $display("FAIL rst_mid_next_rsp: got latency=%0d id=%0d value=%0d expected 22 0 8",
               n, RSP_ID, RSP_VALUE);
    end
    tick();
  endtask

  task automatic test_done_edges();
    int n;
    do_reset();
    core_delay = 32;
    REQ_ANGLE  = {8'd120, 8'd0, 8'd0, 8'd1};
    REQ_VALID  = 4'b1000;
    #1;
    checks++;
    if (REQ_READY !== 4'b1000) begin
      errors++;
      $display("FAIL edge_grant: got %b expected 1000", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    n = 0;
    while (!RSP_VALID && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n != 33 || RSP_ID !== 2'd3 || RSP_VALUE !== 8'd121 || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL edge_done_on_timeout: got latency=%0d id=%0d value=%0d err=%b expected 33 3 121 0",
               n, RSP_ID, RSP_VALUE, RSP_ERR);
    end
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || RSP_VALID !== 1'b0 || CORE_START !== 1'b0) begin
      errors++;
      $display("FAIL edge_idle_done: got busy=%b rsp_valid=%b start=%b expected 0 0 0",
               BUSY, RSP_VALID, CORE_START);
    end
    core_delay = 1;
    REQ_VALID  = 4'b0001;
    #1;
    checks++;
    if (REQ_READY !== 4'b0001) begin
      errors++;
      $display("FAIL edge_wrap_grant: got %b expected 0001", REQ_READY);
    end
    tick();
    REQ_VALID = '0;
    n = 1;
    while (!RSP_VALID && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 3 || RSP_ID !== 2'd0 || RSP_VALUE !== 8'd2 || RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL edge_min_latency: got latency=%0d id=%0d value=%0d err=%b expected 3 0 2 0",
               n, RSP_ID, RSP_VALUE, RSP_ERR);
    end
    tick();
  endtask

  initial begin
    RESET_PULSE = 1'b0;
    REQ_VALID   = '0;
    REQ_ANGLE   = '0;
    RSP_READY   = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_done_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
